pipeline_control: RTL and testbench

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control_if.sv | 42 ++++
 rtl/pipeline_control.sv | 135 +++++++++++++
 tb/tb_pipeline_control.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_control_if.sv
// Control/status bundle between the pipeline datapath and its control FSM.
// The datapath side is the master; pipeline_control is the slave.
interface pipeline_control_if #(
   parameter int unsigned CYCLE_CNT_WIDTH = 32,
   parameter int unsigned STALL_CNT_WIDTH = 16,
   parameter int unsigned REG_ADDR_WIDTH  = 5
);
   logic                       start;
   logic                       mode;
   logic                       step;
   logic                       clear;
   logic                       halt_detected;
   logic                       id_ex_mem_read;
   logic [REG_ADDR_WIDTH-1:0]  id_ex_rt;
   logic [REG_ADDR_WIDTH-1:0]  if_id_rs;
   logic [REG_ADDR_WIDTH-1:0]  if_id_rt;
   logic                       branch_taken;

   logic                       pipe_enable;
   logic                       pc_write;
   logic                       if_id_write;
   logic                       if_id_flush;
   logic                       id_ex_bubble;
   logic [1:0]                 state;
   logic                       halted;
   logic [CYCLE_CNT_WIDTH-1:0] cycle_count;
   logic [STALL_CNT_WIDTH-1:0] stall_count;

   modport master (
      output start, mode, step, clear, halt_detected,
      output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, branch_taken,
      input  pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble,
      input  state, halted, cycle_count, stall_count
   );

   modport slave (
      input  start, mode, step, clear, halt_detected,
      input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, branch_taken,
      output pipe_enable, pc_write, if_id_write, if_id_flush, id_ex_bubble,
      output state, halted, cycle_count, stall_count
   );
endinterface

// File: rtl/pipeline_control.sv
// Run/step/halt sequencer for a 5-stage pipeline with load-use stall and
// branch flush control, plus saturating executed-cycle and stall counters.
module pipeline_control #(
   parameter int unsigned CYCLE_CNT_WIDTH = 32,
   parameter int unsigned STALL_CNT_WIDTH = 16,
   parameter int unsigned REG_ADDR_WIDTH  = 5
) (
   input logic               clk,
   input logic               rst_n,
   pipeline_control_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      RUN       = 2'b01,
      STEP_WAIT = 2'b10,
      HALTED    = 2'b11
   } state_e;

   localparam logic [CYCLE_CNT_WIDTH-1:0] CYC_MAX  = '1;
   localparam logic [CYCLE_CNT_WIDTH-1:0] CYC_ONE  = CYCLE_CNT_WIDTH'(1);
   localparam logic [STALL_CNT_WIDTH-1:0] STL_MAX  = '1;
   localparam logic [STALL_CNT_WIDTH-1:0] STL_ONE  = STALL_CNT_WIDTH'(1);
   localparam logic [REG_ADDR_WIDTH-1:0]  ZERO_REG = '0;

   state_e                     state_q, state_d;
   logic                       step_q;
   logic [CYCLE_CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

   logic step_pulse;
   logic load_use;
   logic enable;
   logic pc_write;
   logic if_id_write;
   logic if_id_flush;
   logic id_ex_bubble;

   // step_q resets high so a step held through reset release is not a press.
   assign step_pulse = bus.step & ~step_q;

   assign load_use = bus.id_ex_mem_read
                   & (bus.id_ex_rt != ZERO_REG)
                   & ((bus.id_ex_rt == bus.if_id_rs) | (bus.id_ex_rt == bus.if_id_rt));

   always_comb begin
      enable = (state_q == RUN) | ((state_q == STEP_WAIT) & step_pulse);
   end

   // Branch redirect outranks the load-use stall: the consumer is flushed anyway.
   always_comb begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      if (enable) begin
         if (bus.branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
         end else if (load_use) begin
            id_ex_bubble = 1'b1;
         end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      stall_d = stall_q;
      if (bus.clear) begin
         state_d = IDLE;
         cycle_d = '0;
         stall_d = '0;
      end else begin
         if (enable && (cycle_q != CYC_MAX)) begin
            cycle_d = cycle_q + CYC_ONE;
         end
         if (id_ex_bubble && (stall_q != STL_MAX)) begin
            stall_d = stall_q + STL_ONE;
         end
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = bus.mode ? STEP_WAIT : RUN;
               end
            end
            RUN, STEP_WAIT: begin
               if (bus.halt_detected) begin
                  state_d = HALTED;
               end
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= 1'b1;
         cycle_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= bus.step;
         cycle_q <= cycle_d;
         stall_q <= stall_d;
      end
   end

   assign bus.pipe_enable  = enable;
   assign bus.pc_write     = pc_write;
   assign bus.if_id_write  = if_id_write;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.state        = state_q;
   assign bus.halted       = (state_q == HALTED);
   assign bus.cycle_count  = cycle_q;
   assign bus.stall_count  = stall_q;

   a_bubble_excl: assert property (@(posedge clk) disable iff (!rst_n)
      id_ex_bubble |-> (!pc_write && !if_id_write && !if_id_flush));
   a_idle_quiet: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == IDLE || state_q == HALTED) |-> !enable);

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: decode table, directed multi-cycle
// sequences, and randomized traffic against a rule-level reference model.
module tb_pipeline_control;
   localparam int unsigned CW = 4;
   localparam int unsigned SW = 4;
   localparam int unsigned AW = 5;
   localparam int CYC_MAX = (1 << CW) - 1;
   localparam int STL_MAX = (1 << SW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pipeline_control_if #(
      .CYCLE_CNT_WIDTH(CW), .STALL_CNT_WIDTH(SW), .REG_ADDR_WIDTH(AW)
   ) bus ();

   pipeline_control #(
      .CYCLE_CNT_WIDTH(CW), .STALL_CNT_WIDTH(SW), .REG_ADDR_WIDTH(AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: 0 idle, 1 running freely, 2 waiting for step presses, 3 halted.
   int m_state;
   bit m_prev;
   int m_cyc;
   int m_stl;

   typedef struct {
      string    name;
      bit       mr;
      bit [4:0] rt;
      bit [4:0] rs;
      bit [4:0] rtc;
      bit       br;
      bit       e_pcw;
      bit       e_ifw;
      bit       e_flush;
      bit       e_bub;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_prev  = 1'b1;
      m_cyc   = 0;
      m_stl   = 0;
   endtask

   function automatic bit p_hazard();
      return bus.id_ex_mem_read && (bus.id_ex_rt != 0) &&
             ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));
   endfunction

   function automatic bit p_en();
      return rst_n && ((m_state == 1) || ((m_state == 2) && bus.step && !m_prev));
   endfunction

   task automatic check_all();
      bit en;
      bit hz;
      bit br;
      en = p_en();
      hz = p_hazard();
      br = bus.branch_taken;
      chk("pipe_enable",  bus.pipe_enable,  en);
      chk("pc_write",     bus.pc_write,     en && (br || !hz));
      chk("if_id_write",  bus.if_id_write,  en && (br || !hz));
      chk("if_id_flush",  bus.if_id_flush,  en && br);
      chk("id_ex_bubble", bus.id_ex_bubble, en && !br && hz);
      chk("state",        bus.state,        m_state);
      chk("halted",       bus.halted,       m_state == 3);
      chk("cycle_count",  bus.cycle_count,  m_cyc);
      chk("stall_count",  bus.stall_count,  m_stl);
   endtask

   task automatic model_update();
      bit en;
      bit bub;
      if (!rst_n) begin
         model_reset();
         return;
      end
      en  = p_en();
      bub = en && !bus.branch_taken && p_hazard();
      if (bus.clear) begin
         m_state = 0;
         m_cyc   = 0;
         m_stl   = 0;
      end else begin
         if (en && m_cyc < CYC_MAX) m_cyc++;
         if (bub && m_stl < STL_MAX) m_stl++;
         case (m_state)
            0: if (bus.start) m_state = bus.mode ? 2 : 1;
            1, 2: if (bus.halt_detected) m_state = 3;
            default: ;
         endcase
      end
      m_prev = bus.step;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic quiet_inputs();
      bus.start          = 1'b0;
      bus.mode           = 1'b0;
      bus.clear          = 1'b0;
      bus.halt_detected  = 1'b0;
      bus.id_ex_mem_read = 1'b0;
      bus.id_ex_rt       = '0;
      bus.if_id_rs       = '0;
      bus.if_id_rt       = '0;
      bus.branch_taken   = 1'b0;
   endtask

   task automatic do_reset(input bit step_val);
      rst_n = 1'b0;
      quiet_inputs();
      bus.step = step_val;
      model_reset();
      #1;
      chk("rst pipe_enable", bus.pipe_enable, 0);
      chk("rst pc_write",    bus.pc_write,    0);
      chk("rst state",       bus.state,       0);
      chk("rst halted",      bus.halted,      0);
      chk("rst cycle_count", bus.cycle_count, 0);
      chk("rst stall_count", bus.stall_count, 0);
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int en_cnt;

      vecs[0] = '{"plain",        0,  5,  5,  0, 0, 1, 1, 0, 0};
      vecs[1] = '{"hit_rs",       1,  5,  5,  3, 0, 0, 0, 0, 1};
      vecs[2] = '{"hit_rt",       1,  7,  1,  7, 0, 0, 0, 0, 1};
      vecs[3] = '{"rt_zero",      1,  0,  0,  0, 0, 1, 1, 0, 0};
      vecs[4] = '{"no_match",     1,  9,  8, 10, 0, 1, 1, 0, 0};
      vecs[5] = '{"branch",       0,  0,  0,  0, 1, 1, 1, 1, 0};
      vecs[6] = '{"branch_hz",    1,  4,  4,  2, 1, 1, 1, 1, 0};
      vecs[7] = '{"hit_both",     1, 31, 31, 31, 0, 0, 0, 0, 1};

      do_reset(1'b0);

      // Continuous run for 10 cycles, then a halt in WB.
      bus.start = 1'b1;
      #1 chk("idle pipe_enable", bus.pipe_enable, 0);
      cycle();
      chk("run entered", bus.state, 1);
      bus.start = 1'b0;
      repeat (10) cycle();
      bus.halt_detected = 1'b1;
      #1 chk("halt cycle enabled", bus.pipe_enable, 1);
      cycle();
      bus.halt_detected = 1'b0;
      #1;
      chk("halt state",       bus.state,       3);
      chk("halt flag",        bus.halted,      1);
      chk("halt cycle_count", bus.cycle_count, 11);
      chk("halt pipe_enable", bus.pipe_enable, 0);
      cycle();

      // Start is ignored while halted; clear returns to idle.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      #1 chk("halted ignores start", bus.state, 3);
      bus.clear = 1'b1;
      cycle();
      bus.clear = 1'b0;
      #1;
      chk("clear state", bus.state, 0);
      chk("clear cycle", bus.cycle_count, 0);
      chk("clear stall", bus.stall_count, 0);

      // Load-use hazard unit in RUN.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      bus.id_ex_mem_read = 1'b1;
      bus.id_ex_rt = 5'd5;
      bus.if_id_rs = 5'd5;
      #1;
      chk("lu pc_write",  bus.pc_write,     0);
      chk("lu if_id_wr",  bus.if_id_write,  0);
      chk("lu bubble",    bus.id_ex_bubble, 1);
      cycle();
      chk("lu stall +1", bus.stall_count, 1);
      bus.id_ex_rt = 5'd0;
      bus.if_id_rs = 5'd0;
      #1 chk("r0 no bubble", bus.id_ex_bubble, 0);
      cycle();
      chk("r0 stall same", bus.stall_count, 1);
      bus.id_ex_rt = 5'd5;
      bus.if_id_rs = 5'd5;
      bus.branch_taken = 1'b1;
      #1;
      chk("br+lu flush",    bus.if_id_flush,  1);
      chk("br+lu pc_write", bus.pc_write,     1);
      chk("br+lu bubble",   bus.id_ex_bubble, 0);
      cycle();
      chk("br+lu stall same", bus.stall_count, 1);

      foreach (vecs[i]) begin
         bus.id_ex_mem_read = vecs[i].mr;
         bus.id_ex_rt       = vecs[i].rt;
         bus.if_id_rs       = vecs[i].rs;
         bus.if_id_rt       = vecs[i].rtc;
         bus.branch_taken   = vecs[i].br;
         #1;
         chk({"vec ", vecs[i].name, " pc_write"}, bus.pc_write,     vecs[i].e_pcw);
         chk({"vec ", vecs[i].name, " if_id_wr"}, bus.if_id_write,  vecs[i].e_ifw);
         chk({"vec ", vecs[i].name, " flush"},    bus.if_id_flush,  vecs[i].e_flush);
         chk({"vec ", vecs[i].name, " bubble"},   bus.id_ex_bubble, vecs[i].e_bub);
         cycle();
      end
      quiet_inputs();

      // Cycle counter saturation, then asynchronous reset mid-RUN.
      bus.clear = 1'b1;
      cycle();
      bus.clear = 1'b0;
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      repeat (20) cycle();
      chk("cycle saturate", bus.cycle_count, 15);
      chk("still running", bus.pipe_enable, 1);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async rst pipe_enable", bus.pipe_enable, 0);
      chk("async rst pc_write",    bus.pc_write,    0);
      chk("async rst state",       bus.state,       0);
      chk("async rst cycle",       bus.cycle_count, 0);
      cycle();
      rst_n = 1'b1;

      // Step mode: step held through reset release, then press pattern.
      do_reset(1'b1);
      bus.start = 1'b1;
      bus.mode  = 1'b1;
      cycle();
      bus.start = 1'b0;
      #1;
      chk("step_wait entered", bus.state, 2);
      chk("held step no pulse", bus.pipe_enable, 0);
      bus.step = 1'b0;
      cycle();
      en_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         bus.step = (k < 5 || k == 7);
         #1 en_cnt += int'(bus.pipe_enable);
         cycle();
      end
      bus.step = 1'b0;
      chk("step enabled cycles", en_cnt, 2);
      chk("step cycle_count", bus.cycle_count, 2);
      cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         rst_n = 1'b1;
         bus.start          = ($urandom_range(0, 3) == 0);
         bus.mode           = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 2) == 0) bus.step = ~bus.step;
         bus.clear          = ($urandom_range(0, 19) == 0);
         bus.halt_detected  = ($urandom_range(0, 15) == 0);
         bus.id_ex_mem_read = $urandom_range(0, 1) == 1;
         bus.id_ex_rt       = AW'($urandom_range(0, 3));
         bus.if_id_rs       = AW'($urandom_range(0, 3));
         bus.if_id_rt       = AW'($urandom_range(0, 3));
         bus.branch_taken   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
